ser8_src_n: RTL

Eight-word parallel-to-serial source stage that sits directly upstream of the 8:1 n-bit read mux. It captures a block of eight n-bit words under a valid/ready handshake, presents the stored words as the mux data array, and steps the 3-bit mux select through 0..7, one beat per downstream handshake. The mux output together with `out_valid_o` and `last_o` forms the serial stream.

---
 rtl/ser8_src_n.sv | 79 +++++++
 1 files changed

// File: rtl/ser8_src_n.sv
// Eight-word parallel-to-serial source feeding an 8:1 read mux.
// Optional `SER8_OVERLAP_EN: accept the next block on the final beat for gapless streaming.
module ser8_src_n #(
  parameter int unsigned n       = 4,
  parameter int unsigned m       = 8,
  parameter int unsigned address = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [0:m-1][n-1:0]   in_data_i,
  output logic [0:m-1][n-1:0]   words_o,
  output logic [address-1:0]    sel_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  last_o
);

  localparam logic [address-1:0] LastSel = address'(m - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e                state_q, state_d;
  logic [address-1:0]    sel_q, sel_d;
  logic [0:m-1][n-1:0]   words_q;
  logic                  ld, bt, at_last;

  assign at_last     = (sel_q == LastSel);
  assign out_valid_o = (state_q == StSend);
`ifdef SER8_OVERLAP_EN
  assign in_ready_o  = (state_q == StIdle) | (out_valid_o & at_last & out_ready_i);
`else
  assign in_ready_o  = (state_q == StIdle);
`endif
  assign ld          = in_valid_i & in_ready_o;
  assign bt          = out_valid_o & out_ready_i;
  assign last_o      = out_valid_o & at_last;
  assign sel_o       = sel_q;
  assign words_o     = words_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      StIdle: ;
      StSend: begin
        if (bt) begin
          if (at_last) begin
            state_d = StIdle;
            sel_d   = '0;
          end else begin
            sel_d = sel_q + address'(1);
          end
        end
      end
    endcase
    // A load wins over the final-beat exit, which only matters with overlap enabled.
    if (ld) begin
      state_d = StSend;
      sel_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sel_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (ld) begin
        words_q <= in_data_i;
      end
    end
  end

endmodule
